i2c_req_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `i2c_dri` byte-transfer engine between `NUM_REQ` independent requesters, such as a sensor init sequencer, an EEPROM reader and a debug port. The block accepts one command at a time through a valid/ready handshake. It drives the engine's `i2c_exec` command interface, waits for `i2c_done`, and returns read data and ACK status to the requester that issued the command. It runs on the engine's `dri_clk` domain and sits directly between the requesters and `i2c_dri`.

---
 rtl/i2c_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/i2c_req_arb.sv | 187 ++++++++++++++++++
 tb/tb_i2c_req_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C requester arbiter.
//   ADDR_W / DATA_W : word-address and data-byte widths of the i2c_dri engine.
//   ST_*            : one-hot FSM state encodings.
//                     ST_RETRY is used only when I2C_ARB_RETRY_EN is defined.
package i2c_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_GRANT = 6'b000010;
    localparam logic [5:0] ST_ISSUE = 6'b000100;
    localparam logic [5:0] ST_WAIT  = 6'b001000;
    localparam logic [5:0] ST_RESP  = 6'b010000;
    localparam logic [5:0] ST_RETRY = 6'b100000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
//   The search starts at last_grant+1 (mod N), so the most recently granted
//   requester has the lowest priority.
//   Ports:
//     req_valid  - pending request bits
//     last_grant - index of the previous winner
//     grant      - one-hot winner; all zeros if nothing is pending
//     idx        - index of the winner
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_valid,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    // Scan from the farthest offset down to offset 1.
    // The nearest valid requester after last_grant overwrites the others and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            for (int j = 0; j < N; j++) begin
                if (j == (int'(last_grant) + i) % N && req_valid[j]) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end
endmodule

// File: rtl/i2c_req_arb.sv
// i2c_req_arb: round-robin arbiter and sequencer that shares one i2c_dri engine
// among NUM_REQ requesters.
//   Optional macro I2C_ARB_RETRY_EN: when a command is NACKed, the arbiter
//   re-issues it up to MAX_RETRY more times.
//   Requester side:
//     req_valid/req_ready                 - one-command handshake
//     req_rh_wl, req_bit_ctrl,
//     req_addr, req_wdata                 - packed per-requester command fields
//     rsp_valid/rsp_rdata/rsp_nack        - one-hot completion and its result
//     busy                                - high from accept through the response cycle
//   Engine side:
//     i2c_exec, i2c_rh_wl, i2c_bit_ctrl,
//     i2c_addr, i2c_data_w                - latched command
//     i2c_data_r, i2c_done, i2c_ack       - engine result
module i2c_req_arb
    import i2c_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_rh_wl,
    input  logic [NUM_REQ-1:0]        req_bit_ctrl,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_nack,
    output logic                      busy,
    output logic                      i2c_exec,
    output logic                      i2c_rh_wl,
    output logic                      i2c_bit_ctrl,
    output logic [ADDR_W-1:0]         i2c_addr,
    output logic [DATA_W-1:0]         i2c_data_w,
    input  logic [DATA_W-1:0]         i2c_data_r,
    input  logic                      i2c_done,
    input  logic                      i2c_ack
);
    localparam int IW = $clog2(NUM_REQ);

    logic [5:0]         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] rspv_q, rspv_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               nack_q, nack_d;
    logic               busy_q, busy_d;
    logic               exec_q, exec_d;
    logic               rh_q, rh_d;
    logic               bc_q, bc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               retry;

`ifdef I2C_ARB_RETRY_EN
    localparam int CW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign retry = i2c_ack && (cnt_q < CW'(MAX_RETRY));
`else
    assign retry = 1'b0;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        ready_d = '0;
        rspv_d  = '0;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        busy_d  = busy_q;
        exec_d  = 1'b0;
        rh_d    = rh_q;
        bc_d    = bc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef I2C_ARB_RETRY_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: if (|req_valid) begin
                state_d = ST_GRANT;
                last_d  = pick_idx;
                owner_d = pick_grant;
                ready_d = pick_grant;
                busy_d  = 1'b1;
                rh_d    = req_rh_wl[pick_idx];
                bc_d    = req_bit_ctrl[pick_idx];
                addr_d  = req_addr[ADDR_W*pick_idx +: ADDR_W];
                wdata_d = req_wdata[DATA_W*pick_idx +: DATA_W];
`ifdef I2C_ARB_RETRY_EN
                cnt_d   = '0;
`endif
            end
            ST_GRANT: state_d = ST_ISSUE;
            // The exec register loads here, so the pulse appears two cycles
            // after req_ready, once the latched fields have settled.
            ST_ISSUE: begin
                state_d = ST_WAIT;
                exec_d  = 1'b1;
            end
            ST_WAIT: if (i2c_done) begin
                if (retry) begin
                    state_d = ST_RETRY;
                end else begin
                    state_d = ST_RESP;
                    rspv_d  = owner_q;
                    rdata_d = i2c_data_r;
                    nack_d  = i2c_ack;
                end
            end
`ifdef I2C_ARB_RETRY_EN
            ST_RETRY: begin
                state_d = ST_ISSUE;
                cnt_d   = cnt_q + CW'(1);
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            owner_q <= '0;
            ready_q <= '0;
            rspv_q  <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            exec_q  <= 1'b0;
            rh_q    <= 1'b0;
            bc_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef I2C_ARB_RETRY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
            exec_q  <= exec_d;
            rh_q    <= rh_d;
            bc_q    <= bc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef I2C_ARB_RETRY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = rspv_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_nack     = nack_q;
    assign busy         = busy_q;
    assign i2c_exec     = exec_q;
    assign i2c_rh_wl    = rh_q;
    assign i2c_bit_ctrl = bc_q;
    assign i2c_addr     = addr_q;
    assign i2c_data_w   = wdata_q;
endmodule

// File: tb/tb_i2c_req_arb.sv
// tb_i2c_req_arb: scoreboard bench for i2c_req_arb with an i2c_dri engine model.
module tb_i2c_req_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, req_rh_wl = '0, req_bit_ctrl = '0, rsp_valid;
    logic [31:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [7:0]  rsp_rdata, i2c_data_w, i2c_data_r;
    logic        rsp_nack, busy, i2c_exec, i2c_rh_wl, i2c_bit_ctrl, i2c_done, i2c_ack;
    logic [15:0] i2c_addr;

    i2c_req_arb dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rh_wl(req_rh_wl), .req_bit_ctrl(req_bit_ctrl), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_nack(rsp_nack), .busy(busy), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
        .i2c_bit_ctrl(i2c_bit_ctrl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
        .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, exec_cnt = 0, eng_delay = 3;
    int ready_cyc = -100, done_cyc = -100;
    bit lat_pend = 0;
    logic [1:0]  ready_q[$];
    logic [25:0] exec_q[$];
    logic [10:0] rsp_q[$];
    logic [8:0]  eng_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=no event want=event", name);
    endtask

    function automatic logic [25:0] ex(input logic rh, input logic bc, input logic [15:0] a, input logic [7:0] d);
        return {rh, bc, a, d};
    endfunction

    function automatic logic [10:0] rs(input logic [1:0] v, input logic [7:0] d, input logic n);
        return {v, d, n};
    endfunction

    task automatic check_zero(input string t);
        chk({t, "_ready"}, 32'(req_ready), 0);
        chk({t, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({t, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({t, "_rsp_nack"}, 32'(rsp_nack), 0);
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_exec"}, 32'(i2c_exec), 0);
        chk({t, "_rh_wl"}, 32'(i2c_rh_wl), 0);
        chk({t, "_bit_ctrl"}, 32'(i2c_bit_ctrl), 0);
        chk({t, "_addr"}, 32'(i2c_addr), 0);
        chk({t, "_data_w"}, 32'(i2c_data_w), 0);
    endtask

    // Engine model: each exec consumes one {ack,data} reply, and the model
    // pulses done after eng_delay cycles; a reset aborts the transfer.
    initial begin
        i2c_done = 1'b0;
        i2c_data_r = '0;
        i2c_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && i2c_exec) begin
                logic [8:0] r;
                bit abort;
                r = (eng_q.size() != 0) ? eng_q.pop_front() : 9'h0;
                exec_cnt++;
                abort = 0;
                for (int i = 0; i < eng_delay; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1;
                        break;
                    end
                end
                if (!abort) begin
                    i2c_done = 1'b1;
                    i2c_ack = r[8];
                    i2c_data_r = r[7:0];
                    done_cyc = cyc;
                    @(negedge clk);
                    i2c_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented output against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != 0) begin
                if (ready_q.size() == 0) chk("unexpected_ready", 32'(req_ready), 0);
                else chk("grant", 32'(req_ready), 32'(ready_q.pop_front()));
                chk("busy_on_grant", 32'(busy), 1);
                ready_cyc = cyc;
                lat_pend = 1;
            end
            if (i2c_exec) begin
                if (exec_q.size() == 0) chk("unexpected_exec", 32'(i2c_exec), 0);
                else chk("exec_fields", 32'({i2c_rh_wl, i2c_bit_ctrl, i2c_addr, i2c_data_w}), 32'(exec_q.pop_front()));
                if (lat_pend) begin
                    chk("exec_latency", 32'(cyc - ready_cyc), 2);
                    lat_pend = 0;
                end
            end
            if (rsp_valid != 0) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                else chk("rsp", 32'({rsp_valid, rsp_rdata, rsp_nack}), 32'(rsp_q.pop_front()));
                chk("rsp_latency", 32'(cyc - done_cyc), 1);
            end
        end
    end

    task automatic req(input int k, input logic rh, input logic bc, input logic [15:0] a, input logic [7:0] d);
        int n;
        req_rh_wl[k] = rh;
        req_bit_ctrl[k] = bc;
        req_addr[16*k +: 16] = a;
        req_wdata[8*k +: 8] = d;
        req_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[k] && n < 100);
        if (!req_ready[k]) timeout("req_ready_wait");
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_q.size() == 0 && !busy) && n < 300);
        if (rsp_q.size() != 0 || busy) timeout(name);
    endtask

    initial begin
        int e0;
        #200000;
        $display("FAIL watchdog: got=hang want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, n;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 0.
        ready_q.push_back(2'b01);
        exec_q.push_back(ex(0, 0, 16'h0010, 8'hA5));
        eng_q.push_back({1'b0, 8'h00});
        rsp_q.push_back(rs(2'b01, 8'h00, 0));
        e0 = exec_cnt;
        req(0, 0, 0, 16'h0010, 8'hA5);
        wait_rsp("write_rsp");
        chk("write_exec_count", 32'(exec_cnt - e0), 1);

        // Read with a 16-bit word address from requester 1.
        ready_q.push_back(2'b10);
        exec_q.push_back(ex(1, 1, 16'h1234, 8'h77));
        eng_q.push_back({1'b0, 8'h5C});
        rsp_q.push_back(rs(2'b10, 8'h5C, 0));
        req(1, 1, 1, 16'h1234, 8'h77);
        chk("read_bit_ctrl", 32'(i2c_bit_ctrl), 1);
        wait_rsp("read_rsp");

        // Contention: both requesters hold valid for four commands.
        req_rh_wl = 2'b10;
        req_bit_ctrl = 2'b00;
        req_addr = {16'h0200, 16'h0100};
        req_wdata = {8'h22, 8'h11};
        for (int g = 0; g < 4; g++) begin
            ready_q.push_back(g[0] ? 2'b10 : 2'b01);
            exec_q.push_back(g[0] ? ex(1, 0, 16'h0200, 8'h22) : ex(0, 0, 16'h0100, 8'h11));
            eng_q.push_back({1'b0, 8'(8'h31 + g)});
            rsp_q.push_back(rs(g[0] ? 2'b10 : 2'b01, 8'(8'h31 + g), 0));
        end
        e0 = exec_cnt;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 0 && n < 100);
            if (req_ready == 0) timeout("contention_ready");
        end
        req_valid = 2'b00;
        wait_rsp("contention_rsp");
        chk("contention_exec_count", 32'(exec_cnt - e0), 4);

`ifdef I2C_ARB_RETRY_EN
        // NACK twice, then ACK: three attempts, success is reported.
        ready_q.push_back(2'b01);
        for (int i = 0; i < 3; i++) exec_q.push_back(ex(0, 0, 16'h0050, 8'h3C));
        eng_q.push_back({1'b1, 8'h90});
        eng_q.push_back({1'b1, 8'h91});
        eng_q.push_back({1'b0, 8'h44});
        rsp_q.push_back(rs(2'b01, 8'h44, 0));
        e0 = exec_cnt;
        req(0, 0, 0, 16'h0050, 8'h3C);
        wait_rsp("retry_ok_rsp");
        chk("retry_ok_exec_count", 32'(exec_cnt - e0), 3);
        // NACK on every attempt: the command is issued MAX_RETRY+1 times.
        ready_q.push_back(2'b01);
        for (int i = 0; i < 4; i++) begin
            exec_q.push_back(ex(0, 0, 16'h0060, 8'h3D));
            eng_q.push_back({1'b1, 8'(8'hA0 + i)});
        end
        rsp_q.push_back(rs(2'b01, 8'hA3, 1));
        e0 = exec_cnt;
        req(0, 0, 0, 16'h0060, 8'h3D);
        wait_rsp("retry_fail_rsp");
        chk("retry_fail_exec_count", 32'(exec_cnt - e0), 4);
`else
        // NACK without retry: a single attempt, and the NACK is reported.
        ready_q.push_back(2'b01);
        exec_q.push_back(ex(0, 0, 16'h0050, 8'h3C));
        eng_q.push_back({1'b1, 8'h99});
        rsp_q.push_back(rs(2'b01, 8'h99, 1));
        e0 = exec_cnt;
        req(0, 0, 0, 16'h0050, 8'h3C);
        wait_rsp("nack_rsp");
        chk("nack_exec_count", 32'(exec_cnt - e0), 1);
`endif

        // Reset during WAIT: outputs clear, and no response is produced.
        eng_delay = 30;
        ready_q.push_back(2'b10);
        exec_q.push_back(ex(1, 1, 16'h0ABC, 8'h5A));
        e0 = exec_cnt;
        req(1, 1, 1, 16'h0ABC, 8'h5A);
        n = 0;
        while (exec_cnt == e0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exec_cnt == e0) timeout("reset_exec_wait");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        eng_delay = 3;
        repeat (40) @(negedge clk);
        chk("reset_no_rsp_pending", 32'(rsp_valid), 0);

        // After reset, requester 0 wins the tie again.
        ready_q.push_back(2'b01);
        exec_q.push_back(ex(0, 0, 16'h0070, 8'h0F));
        eng_q.push_back({1'b0, 8'hE1});
        rsp_q.push_back(rs(2'b01, 8'hE1, 0));
        req_rh_wl = 2'b00;
        req_bit_ctrl = 2'b00;
        req_addr = {16'h0080, 16'h0070};
        req_wdata = {8'hF0, 8'h0F};
        req_valid = 2'b11;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 0 && n < 100);
        if (req_ready == 0) timeout("post_reset_ready");
        req_valid = 2'b00;
        wait_rsp("post_reset_rsp");

        chk("ready_q_empty", 32'(ready_q.size()), 0);
        chk("exec_q_empty", 32'(exec_q.size()), 0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
